// File: rtl/load_store_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_store_unit_if                                                    |
// | Request/ready data-memory bus between the LSU and data memory.        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output mem_wmask,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wmask,
    output mem_ready,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_store_unit                                                       |
// | Memory stage: one RV32I load/store per request, with extension,       |
// | misalignment/illegal-code detection and bus timeout.                  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module load_store_unit #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              is_store_i,
  input  logic [2:0]        funct3_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       store_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       load_data_o,
  output logic              misaligned_o,
  output logic              bus_err_o,
  load_store_unit_if.master mem
);

  localparam logic [15:0] c_wait_last = 16'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] wait_q, wait_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] ld_q, ld_d;
  logic        misal_q, misal_d;
  logic        berr_q, berr_d;

  logic        w_code_ok;
  logic        w_aligned;
  logic        w_illegal;
  logic [3:0]  w_wmask;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ldext;
  logic        w_in_req;

  // Legality of the request presented on the inputs this cycle
  always_comb begin
    w_code_ok = 1'b0;
    w_aligned = 1'b1;
    case (funct3_i)
      3'b000, 3'b001, 3'b010: w_code_ok = 1'b1;
      3'b100, 3'b101:         w_code_ok = !is_store_i;
      default:                w_code_ok = 1'b0;
    endcase
    case (funct3_i[1:0])
      2'b01:   w_aligned = !addr_i[0];
      2'b10:   w_aligned = (addr_i[1:0] == 2'b00);
      default: w_aligned = 1'b1;
    endcase
    w_illegal = !w_code_ok || !w_aligned;
  end

  // Byte-lane placement of store data
  always_comb begin
    w_wmask = 4'b1111;
    w_wdata = sdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        w_wmask = 4'b0001 << addr_q[1:0];
        w_wdata = {4{sdata_q[7:0]}};
      end
      2'b01: begin
        w_wmask = 4'b0011 << addr_q[1:0];
        w_wdata = {2{sdata_q[15:0]}};
      end
      default: begin
        w_wmask = 4'b1111;
        w_wdata = sdata_q;
      end
    endcase
  end

  // Lane selection and extension of the returned read word
  always_comb begin
    w_byte  = 8'(mem.mem_rdata >> {addr_q[1:0], 3'b000});
    w_half  = addr_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    w_ldext = 32'd0;
    case (funct3_q)
      3'b000:  w_ldext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ldext = {{16{w_half[15]}}, w_half};
      3'b010:  w_ldext = mem.mem_rdata;
      3'b100:  w_ldext = {24'd0, w_byte};
      3'b101:  w_ldext = {16'd0, w_half};
      default: w_ldext = 32'd0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    sdata_d    = sdata_q;
    ld_d       = ld_q;
    misal_d    = misal_q;
    berr_d     = berr_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          is_store_d = is_store_i;
          funct3_d   = funct3_i;
          addr_d     = addr_i;
          sdata_d    = store_data_i;
          misal_d    = w_illegal;
          berr_d     = 1'b0;
          wait_d     = 16'd0;
          if (w_illegal) begin
            ld_d    = 32'd0;
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem.mem_ready) begin
          ld_d    = is_store_q ? 32'd0 : w_ldext;
          state_d = S_DONE;
        end else if (wait_q == c_wait_last) begin
          // Final allowed stall cycle: abort instead of counting further
          ld_d    = 32'd0;
          berr_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wait_q     <= 16'd0;
      is_store_q <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= 32'd0;
      sdata_q    <= 32'd0;
      ld_q       <= 32'd0;
      misal_q    <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      sdata_q    <= sdata_d;
      ld_q       <= ld_d;
      misal_q    <= misal_d;
      berr_q     <= berr_d;
    end
  end

  // Bus outputs are driven only while requesting so they read zero elsewhere
  assign w_in_req      = (state_q == S_REQ);
  assign mem.mem_req   = w_in_req;
  assign mem.mem_we    = w_in_req && is_store_q;
  assign mem.mem_addr  = w_in_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem.mem_wdata = (w_in_req && is_store_q) ? w_wdata : 32'd0;
  assign mem.mem_wmask = (w_in_req && is_store_q) ? w_wmask : 4'b0000;

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign misaligned_o = done_o && misal_q;
  assign bus_err_o    = done_o && berr_q;
  assign load_data_o  = ld_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_load_store_unit                                                    |
// | Two LSUs (MAX_WAIT 255 and 4) driven in lock-step against a model.    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_st = 1'b0;
  logic [2:0]  f3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] sdata = 32'd0;
  logic [31:0] rdata_bus = 32'd0;
  int          ready_delay = 0;

  int vectors = 0;
  int errors  = 0;
  int maxw[2] = '{255, 4};

  logic        busy_m[2], done_m[2], misal_m[2], berr_m[2];
  logic [31:0] ld_m[2];
  logic        req_m[2], we_m[2];
  logic [31:0] maddr_m[2], wdata_m[2];
  logic [3:0]  wmask_m[2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    load_store_unit_if mif();
    int cnt = 0;

    // Memory responds after ready_delay stalled request cycles
    always @(posedge clk) cnt <= mif.mem_req ? cnt + 1 : 0;
    assign mif.mem_ready = mif.mem_req && (cnt >= ready_delay);
    assign mif.mem_rdata = rdata_bus;
    assign req_m[g]   = mif.mem_req;
    assign we_m[g]    = mif.mem_we;
    assign maddr_m[g] = mif.mem_addr;
    assign wdata_m[g] = mif.mem_wdata;
    assign wmask_m[g] = mif.mem_wmask;

    load_store_unit #(.MAX_WAIT((g == 0) ? 255 : 4)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start),
      .is_store_i   (is_st),
      .funct3_i     (f3),
      .addr_i       (addr),
      .store_data_i (sdata),
      .busy_o       (busy_m[g]),
      .done_o       (done_m[g]),
      .load_data_o  (ld_m[g]),
      .misaligned_o (misal_m[g]),
      .bus_err_o    (berr_m[g]),
      .mem          (mif)
    );
  end

  task automatic chk(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, g, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    for (int g = 0; g < 2; g++) begin
      chk({tag, "_busy"}, g, 32'(busy_m[g]), 32'd0);
      chk({tag, "_done"}, g, 32'(done_m[g]), 32'd0);
      chk({tag, "_req"},  g, 32'(req_m[g]),  32'd0);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] fc, input logic [31:0] a, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    int          v;
    b = 8'((rd >> (8 * a[1:0])) & 32'hFF);
    h = 16'((rd >> (16 * a[1])) & 32'hFFFF);
    case (fc)
      3'd0: begin v = $signed(b); return 32'(v); end
      3'd1: begin v = $signed(h); return 32'(v); end
      3'd2: return rd;
      3'd4: return 32'(b);
      3'd5: return 32'(h);
      default: return 32'd0;
    endcase
  endfunction

  // One access: present it, optionally poke start while busy, then follow
  // both DUTs cycle by cycle through request, done and back to idle.
  task automatic do_access(input bit st, input logic [2:0] fc, input logic [31:0] a,
                           input logic [31:0] sd, input logic [31:0] rd, input int dly, input bit poke);
    bit          code_ok, legal, to[2];
    int          size, k[2], total;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wdata, exp_ld[2];
    code_ok  = st ? (fc inside {3'd0, 3'd1, 3'd2}) : (fc inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size     = 1 << fc[1:0];
    legal    = code_ok && ((a % size) == 0);
    exp_mask = 4'(((1 << size) - 1) << a[1:0]);
    for (int i = 0; i < 4; i++) exp_wdata[8*i +: 8] = sd[8*(i % size) +: 8];
    total = 0;
    for (int g = 0; g < 2; g++) begin
      to[g]     = legal && (dly >= maxw[g]);
      k[g]      = !legal ? 0 : (to[g] ? maxw[g] : dly + 1);
      exp_ld[g] = (!legal || st || to[g]) ? 32'd0 : model_load(fc, a, rd);
      if (k[g] + 2 > total) total = k[g] + 2;
    end
    @(negedge clk);
    start = 1'b1; is_st = st; f3 = fc; addr = a; sdata = sd;
    rdata_bus = rd; ready_delay = dly;
    @(negedge clk);
    if (poke && legal) begin
      start = 1'b1; is_st = ~st; f3 = 3'd2; addr = $urandom & 32'hFFFF_FFFC; sdata = $urandom;
    end else begin
      start = 1'b0;
    end
    for (int c = 1; c <= total; c++) begin
      if (c == 2) start = 1'b0;
      for (int g = 0; g < 2; g++) begin
        if (c <= k[g]) begin
          chk("req",   g, 32'(req_m[g]),  32'd1);
          chk("busy",  g, 32'(busy_m[g]), 32'd1);
          chk("done",  g, 32'(done_m[g]), 32'd0);
          chk("maddr", g, maddr_m[g],     {a[31:2], 2'b00});
          chk("we",    g, 32'(we_m[g]),   32'(st));
          chk("wmask", g, 32'(wmask_m[g]), st ? 32'(exp_mask) : 32'd0);
          if (st) chk("wdata", g, wdata_m[g], exp_wdata);
        end else if (c == k[g] + 1) begin
          chk("done",  g, 32'(done_m[g]),  32'd1);
          chk("busy",  g, 32'(busy_m[g]),  32'd1);
          chk("req",   g, 32'(req_m[g]),   32'd0);
          chk("misal", g, 32'(misal_m[g]), 32'(!legal));
          chk("berr",  g, 32'(berr_m[g]),  32'(to[g]));
          chk("ldata", g, ld_m[g],         exp_ld[g]);
        end else begin
          chk("idle_busy",  g, 32'(busy_m[g]),  32'd0);
          chk("idle_done",  g, 32'(done_m[g]),  32'd0);
          chk("idle_req",   g, 32'(req_m[g]),   32'd0);
          chk("idle_misal", g, 32'(misal_m[g]), 32'd0);
          chk("idle_berr",  g, 32'(berr_m[g]),  32'd0);
          chk("hold_ldata", g, ld_m[g],         exp_ld[g]);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_busy",  g, 32'(busy_m[g]),  32'd0);
      chk("rst_done",  g, 32'(done_m[g]),  32'd0);
      chk("rst_ldata", g, ld_m[g],         32'd0);
      chk("rst_req",   g, 32'(req_m[g]),   32'd0);
      chk("rst_wmask", g, 32'(wmask_m[g]), 32'd0);
      chk("rst_misal", g, 32'(misal_m[g]), 32'd0);
      chk("rst_berr",  g, 32'(berr_m[g]),  32'd0);
    end
    rst_n = 1'b1;

    do_access(1'b0, 3'd0, 32'h0000_1003, 32'd0, 32'h80FF_1234, 0, 1'b0);
    do_access(1'b0, 3'd4, 32'h0000_1003, 32'd0, 32'h80FF_1234, 0, 1'b0);
    do_access(1'b1, 3'd1, 32'h0000_2002, 32'hDEAD_BEEF, 32'h1111_2222, 0, 1'b0);
    do_access(1'b1, 3'd0, 32'h0000_2001, 32'hCAFE_F00D, 32'd0, 1, 1'b0);
    do_access(1'b0, 3'd2, 32'h0000_3001, 32'd0, 32'h5555_AAAA, 0, 1'b0);
    do_access(1'b0, 3'd3, 32'h0000_3000, 32'd0, 32'h5555_AAAA, 0, 1'b0);
    do_access(1'b1, 3'd4, 32'h0000_3000, 32'h1234_5678, 32'd0, 0, 1'b0);
    do_access(1'b0, 3'd1, 32'h0000_3003, 32'd0, 32'h5555_AAAA, 0, 1'b0);
    do_access(1'b0, 3'd2, 32'h0000_4000, 32'd0, 32'h89AB_CDEF, 3, 1'b1);
    do_access(1'b0, 3'd5, 32'h0000_4002, 32'd0, 32'hF00D_8001, 2, 1'b1);
    do_access(1'b0, 3'd2, 32'h0000_5004, 32'd0, 32'h7777_7777, 1000, 1'b0);

    // Reset in the middle of a stalled request
    @(negedge clk);
    start = 1'b1; is_st = 1'b0; f3 = 3'd2; addr = 32'h0000_6000; ready_delay = 1000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) chk("pre_rst_req", g, 32'(req_m[g]), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_idle("async_rst");
    @(negedge clk);
    chk_idle("in_rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_rst");
    do_access(1'b0, 3'd1, 32'h0000_6002, 32'd0, 32'h9234_5678, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra;
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
      do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom, $urandom,
                int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
`default_nettype wire
